// File: rtl/mux_serializer_if.sv
// mux_serializer_if: word handshake, mux drive/return and serial stream bundle for mux_serializer
// slave  (serializer): in_data/in_valid/mux_out/ser_ready in; in_ready/mux_a/mux_sel/ser_data/ser_valid/ser_last out
// master (environment): the opposite directions
interface mux_serializer_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] mux_a;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_out;
  logic              ser_data;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_last;
  modport slave (
    input  in_data, in_valid, mux_out, ser_ready,
    output in_ready, mux_a, mux_sel, ser_data, ser_valid, ser_last
  );
  modport master (
    output in_data, in_valid, mux_out, ser_ready,
    input  in_ready, mux_a, mux_sel, ser_data, ser_valid, ser_last
  );
endinterface

// File: rtl/mux_serializer.sv
// mux_serializer: holds a handshaked word on an 8:1 mux and streams its output LSB first with valid/ready
// Ports: clk, rst (sync, active-high), bus (mux_serializer_if.slave).
// Define MUX_SER_PARITY_EN to append an even-parity bit built from the accepted mux_out values.
module mux_serializer #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input logic            clk,
  input logic            rst,
  mux_serializer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
`ifdef MUX_SER_PARITY_EN
    PAR,
`endif
    SEND
  } state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              accept, hs, last_bit;
`ifdef MUX_SER_PARITY_EN
  logic              par_q, par_d;
`endif
  assign accept   = bus.in_valid && bus.in_ready;
  assign hs       = bus.ser_valid && bus.ser_ready;
  assign last_bit = sel_q == SEL_W'(DATA_W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      sel_q   <= '0;
`ifdef MUX_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sel_q   <= sel_d;
`ifdef MUX_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = SEND;
`ifdef MUX_SER_PARITY_EN
    if (state_q == SEND && hs && last_bit) state_d = PAR;
    if (state_q == PAR && hs) state_d = IDLE;
`else
    if (state_q == SEND && hs && last_bit) state_d = IDLE;
`endif
  end
  // sel stops at the last index and is left there until the next word is accepted
  always_comb begin
    a_d   = accept ? bus.in_data : a_q;
    sel_d = accept ? '0 : (state_q == SEND && hs && !last_bit) ? sel_q + 1'b1 : sel_q;
`ifdef MUX_SER_PARITY_EN
    par_d = accept ? 1'b0 : (state_q == SEND && hs) ? par_q ^ bus.mux_out : par_q;
`endif
  end
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.ser_valid = state_q != IDLE;
    bus.mux_a     = a_q;
    bus.mux_sel   = sel_q;
`ifdef MUX_SER_PARITY_EN
    bus.ser_data  = state_q == SEND ? bus.mux_out : state_q == PAR ? par_q : 1'b0;
    bus.ser_last  = state_q == PAR;
`else
    bus.ser_data  = state_q == SEND && bus.mux_out;
    bus.ser_last  = state_q == SEND && last_bit;
`endif
  end
endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: directed frame, backpressure, busy, reset and back-to-back checks for mux_serializer
module tb_mux_serializer;
`ifdef MUX_SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  mux_serializer_if #(.DATA_W(8), .SEL_W(3)) bus ();
  mux_serializer #(.DATA_W(8), .SEL_W(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.mux_out = bus.mux_a[bus.mux_sel];
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_valid"}, 32'(bus.ser_valid), 0);
    check({tag, "_last"}, 32'(bus.ser_last), 0);
    check({tag, "_data"}, 32'(bus.ser_data), 0);
  endtask
  // starts in the first cycle after the accepting edge; bp stalls with ready pattern 1,0,0,1,0,0...
  task automatic frame(input logic [7:0] w, input logic [7:0] keep_in, input bit bp, input string tag);
    int k = 0;
    int c = 0;
    logic exp_bit;
    while (k < FL && c < 100) begin
      bus.ser_ready = bp ? (c % 3 == 0) : 1'b1;
      exp_bit = k < 8 ? w[k] : ^w;
      check({tag, "_valid"}, 32'(bus.ser_valid), 1);
      check({tag, "_data"}, 32'(bus.ser_data), 32'(exp_bit));
      check({tag, "_sel"}, 32'(bus.mux_sel), k < 8 ? k : 7);
      check({tag, "_last"}, 32'(bus.ser_last), 32'(k == FL - 1));
      check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
      check({tag, "_mux_a"}, 32'(bus.mux_a), 32'(keep_in));
      if (bus.ser_ready) k++;
      tick();
      c++;
    end
    bus.ser_ready = 1'b1;
    check({tag, "_bits"}, k, FL);
    if (!bp) check({tag, "_cycles"}, c, FL);
    check({tag, "_in_ready_after"}, 32'(bus.in_ready), 1);
    check({tag, "_valid_after"}, 32'(bus.ser_valid), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ser_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_mux_a", 32'(bus.mux_a), 0);
    check("reset_sel", 32'(bus.mux_sel), 0);
    send(8'hA5);
    frame(8'hA5, 8'hA5, 1'b0, "a5");
    send(8'h3C);
    frame(8'h3C, 8'h3C, 1'b1, "bp3c");
    send(8'h01);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    frame(8'h01, 8'h01, 1'b0, "busy01");
    check("busy_accept_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    frame(8'hFF, 8'hFF, 1'b0, "ff");
    send(8'hF0);
    tick();
    tick();
    tick();
    check("f0_sel_before_rst", 32'(bus.mux_sel), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_sel", 32'(bus.mux_sel), 0);
    check("midrst_mux_a", 32'(bus.mux_a), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_quiet", 32'(bus.ser_valid), 0);
    end
`ifdef MUX_SER_PARITY_EN
    send(8'h07);
    frame(8'h07, 8'h07, 1'b0, "par07");
    send(8'h03);
    frame(8'h03, 8'h03, 1'b0, "par03");
`endif
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h80;
    tick();
    frame(8'h80, 8'h80, 1'b0, "b2b80");
    bus.in_data = 8'h01;
    check("b2b_gap_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    frame(8'h01, 8'h01, 1'b0, "b2b01");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
